cache_ctrl: RTL and testbench

Sequencing controller for the 2-way set-associative, write-back, LRU cache in front of the 1 KB main memory (10-bit byte address, 32-bit words). It owns the tag, valid, dirty and LRU state and drives the external data array and the main-memory word port. It accepts one CPU request at a time and runs the hit, write-back and refill sequences.

---
 rtl/cache_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a 2-way set-associative, write-back,
// LRU cache. Holds tag/valid/dirty/LRU state, drives the external data array
// and the main-memory word port, and runs hit, write-back and refill flows.
module cache_ctrl #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 2,
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK),
  localparam int OFF_W  = 2 + WORD_W,
  localparam int IDX_W  = $clog2(NUM_SETS),
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hit,
  output logic              da_way,
  output logic [IDX_W-1:0]  da_index,
  output logic [WORD_W-1:0] da_word,
  output logic              da_we,
  output logic [DATA_W-1:0] da_wdata,
  input  logic [DATA_W-1:0] da_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL} state_t;

  state_t state, state_nx;

  // Latched request
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Miss bookkeeping
  logic              miss;
  logic              victim;
  logic [WORD_W-1:0] cnt;

  // Cache state: per set, two ways
  logic [TAG_W-1:0]             tag_q [NUM_SETS][2];
  logic [NUM_SETS-1:0][1:0]     valid_q;
  logic [NUM_SETS-1:0][1:0]     dirty_q;
  logic [NUM_SETS-1:0]          lru_q;   // way to evict next

  // Byte offset within a word is irrelevant for word accesses
  logic unused_byte_bits;
  assign unused_byte_bits = ^cpu_addr[1:0];

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              hit0, hit1, hit, hit_way, pick_way, last;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_word = req_addr[OFF_W-1:2];

  assign hit0    = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
  assign hit1    = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
  assign hit     = hit0 || hit1;
  assign hit_way = hit1;
  assign last    = (cnt == WORD_W'(WORDS_PER_BLOCK - 1));

  // Victim choice: first invalid way, else the LRU way of the set
  always_comb begin
    pick_way = lru_q[req_idx];
    if (!valid_q[req_idx][0])      pick_way = 1'b0;
    else if (!valid_q[req_idx][1]) pick_way = 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and output decode
  always_comb begin
    state_nx       = state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_rdata      = '0;
    cpu_hit        = 1'b0;
    da_way         = victim;
    da_index       = req_idx;
    da_word        = cnt;
    da_we          = 1'b0;
    da_wdata       = req_wdata;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (state)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) state_nx = S_LOOKUP;
      end
      S_LOOKUP: begin
        da_way  = hit_way;
        da_word = req_word;
        if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_hit        = !miss;
          if (req_rw) da_we     = 1'b1;
          else        cpu_rdata = da_rdata;
          state_nx = S_IDLE;
        end else if (valid_q[req_idx][pick_way] && dirty_q[req_idx][pick_way]) begin
          state_nx = S_WB;
        end else begin
          state_nx = S_FILL;
        end
      end
      S_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[req_idx][victim], req_idx, cnt, 2'b00};
        mem_wdata = da_rdata;
        if (mem_ack && last) state_nx = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, cnt, 2'b00};
        da_wdata = mem_rdata;
        if (mem_ack) da_we = 1'b1;
        if (mem_ack && last) state_nx = S_LOOKUP;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, valid/dirty/LRU bookkeeping and word counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_rw    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      miss      <= 1'b0;
      victim    <= 1'b0;
      cnt       <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req_valid) begin
            req_rw    <= cpu_rw;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            miss      <= 1'b0;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            lru_q[req_idx] <= ~hit_way;
            if (req_rw) dirty_q[req_idx][hit_way] <= 1'b1;
          end else begin
            miss   <= 1'b1;
            victim <= pick_way;
            cnt    <= '0;
          end
        end
        S_WB: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              cnt                      <= '0;
              dirty_q[req_idx][victim] <= 1'b0;
            end
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              cnt                      <= '0;
              valid_q[req_idx][victim] <= 1'b1;
              dirty_q[req_idx][victim] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Tag write at the end of a refill; tags are qualified by valid bits
  always_ff @(posedge clk) begin
    if (state == S_FILL && mem_ack && last) tag_q[req_idx][victim] <= req_tag;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench for cache_ctrl with a behavioural data array
// and a word-wide main memory with programmable ack latency.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid, cpu_req_ready, cpu_rw;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_resp_valid, cpu_hit;
  logic        da_way;
  logic [0:0]  da_index;
  logic [1:0]  da_word;
  logic        da_we;
  logic [31:0] da_wdata, da_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  cache_ctrl #(
    .ADDR_W(10),
    .DATA_W(32),
    .WORDS_PER_BLOCK(4),
    .NUM_SETS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .da_way(da_way), .da_index(da_index), .da_word(da_word),
    .da_we(da_we), .da_wdata(da_wdata), .da_rdata(da_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Environment models
  logic [31:0] mem  [256];
  logic [31:0] darr [16];
  logic [9:0]  rd_q [$];
  logic [9:0]  wr_q [$];
  int          ack_delay = 0;
  int          mreq_cyc  = 0;
  int          cyc       = 0;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign da_rdata  = darr[{da_way, da_index, da_word}];

  // Main memory: word i initialised to i * 0x00010001, ack after ack_delay waits
  initial begin : mem_model
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = i * 32'h0001_0001;
    forever begin
      @(posedge clk);
      cyc++;
      if (mem_req) mreq_cyc++;
      if (mem_req && !mem_ack) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  <= 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_q.push_back(mem_addr);
          end else begin
            rd_q.push_back(mem_addr);
          end
        end else begin
          mem_ack <= 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  <= 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Data array: synchronous write, combinational read
  initial begin : da_model
    for (int i = 0; i < 16; i++) darr[i] = '0;
    forever begin
      @(posedge clk);
      if (da_we) darr[{da_way, da_index, da_word}] <= da_wdata;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] r_data;
  logic        r_hit;
  int          r_lat;
  int          r_cyc;

  // One request; r_lat counts cycles from acceptance to the response strobe
  task automatic do_req(input logic rw, input logic [9:0] addr, input logic [31:0] wd);
    int n;
    @(negedge clk);
    n = 0;
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    cpu_req_valid = 1'b1;
    cpu_rw        = rw;
    cpu_addr      = addr;
    cpu_wdata     = wd;
    @(negedge clk);
    cpu_req_valid = 1'b0;
    r_lat = 1;
    while (!cpu_resp_valid && r_lat < 200) begin
      @(negedge clk);
      r_lat++;
    end
    r_data = cpu_rdata;
    r_hit  = cpu_hit;
    r_cyc  = cyc;
  endtask

  logic        t_rw   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [9:0]  t_addr [6] = '{10'h014, 10'h010, 10'h014, 10'h010, 10'h010, 10'h014};
  logic [31:0] t_data [6] = '{32'hAAAA_5555, 32'h0004_0004, 32'hAAAA_5555,
                              32'h1234_5678, 32'h1234_5678, 32'hAAAA_5555};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int rd0, wr0, mq0, prev_cyc;
    logic seen_ready, seen_resp;

    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_rw = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cpu_req_ready), 32'd1);
    check("rst_resp", 32'(cpu_resp_valid), 32'd0);
    check("rst_hit", 32'(cpu_hit), 32'd0);
    check("rst_da_we", 32'(da_we), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    rst_n = 1'b1;

    // Cold read miss of 0x000: fill only
    rd0 = rd_q.size(); wr0 = wr_q.size();
    do_req(1'b0, 10'h000, '0);
    check("t1_lat", 32'(r_lat), 32'd10);
    check("t1_hit", 32'(r_hit), 32'd0);
    check("t1_data", r_data, 32'h0000_0000);
    check("t1_nrd", 32'(rd_q.size() - rd0), 32'd4);
    for (int k = 0; k < 4; k++)
      if (rd_q.size() > rd0 + k) check("t1_rdaddr", 32'(rd_q[rd0 + k]), 32'(4 * k));
    check("t1_nwr", 32'(wr_q.size() - wr0), 32'd0);

    // Write hit, then read it back
    mq0 = mreq_cyc;
    do_req(1'b1, 10'h000, 32'h0000_00FF);
    check("t2_wlat", 32'(r_lat), 32'd1);
    check("t2_whit", 32'(r_hit), 32'd1);
    check("t2_memreq", 32'(mreq_cyc - mq0), 32'd0);
    check("t2_mem0", mem[0], 32'h0000_0000);
    do_req(1'b0, 10'h000, '0);
    check("t2_rlat", 32'(r_lat), 32'd1);
    check("t2_rhit", 32'(r_hit), 32'd1);
    check("t2_rdata", r_data, 32'h0000_00FF);

    // Miss into way 1 of set 0, no write-back
    wr0 = wr_q.size();
    do_req(1'b0, 10'h200, '0);
    check("t3_lat", 32'(r_lat), 32'd10);
    check("t3_hit", 32'(r_hit), 32'd0);
    check("t3_data", r_data, 32'h0080_0080);
    check("t3_nwr", 32'(wr_q.size() - wr0), 32'd0);
    do_req(1'b0, 10'h000, '0);
    check("t3_rehit", 32'(r_hit), 32'd1);
    check("t3_redata", r_data, 32'h0000_00FF);

    // LRU clean victim (way 1), then dirty victim (way 0) with write-back
    wr0 = wr_q.size();
    do_req(1'b0, 10'h300, '0);
    check("t4a_lat", 32'(r_lat), 32'd10);
    check("t4a_hit", 32'(r_hit), 32'd0);
    check("t4a_data", r_data, 32'h00C0_00C0);
    check("t4a_nwr", 32'(wr_q.size() - wr0), 32'd0);
    rd0 = rd_q.size(); wr0 = wr_q.size();
    do_req(1'b0, 10'h200, '0);
    check("t4b_lat", 32'(r_lat), 32'd18);
    check("t4b_hit", 32'(r_hit), 32'd0);
    check("t4b_data", r_data, 32'h0080_0080);
    check("t4b_nwr", 32'(wr_q.size() - wr0), 32'd4);
    for (int k = 0; k < 4; k++)
      if (wr_q.size() > wr0 + k) check("t4b_wraddr", 32'(wr_q[wr0 + k]), 32'(4 * k));
    check("t4b_nrd", 32'(rd_q.size() - rd0), 32'd4);
    for (int k = 0; k < 4; k++)
      if (rd_q.size() > rd0 + k) check("t4b_rdaddr", 32'(rd_q[rd0 + k]), 32'(10'h200 + 4 * k));
    check("t4b_mem0", mem[0], 32'h0000_00FF);
    check("t4b_mem1", mem[1], 32'h0001_0001);

    // Slow memory with request held; reset mid-fill
    ack_delay = 3;
    @(negedge clk);
    check("t5_ready_idle", 32'(cpu_req_ready), 32'd1);
    cpu_req_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h000;
    @(negedge clk);
    seen_ready = 1'b0; seen_resp = 1'b0;
    repeat (8) begin
      seen_ready |= cpu_req_ready;
      seen_resp  |= cpu_resp_valid;
      @(negedge clk);
    end
    check("t5_ready_held", 32'(seen_ready), 32'd0);
    check("t5_no_resp", 32'(seen_resp), 32'd0);
    check("t5_in_fill_req", 32'(mem_req), 32'd1);
    check("t5_in_fill_we", 32'(mem_we), 32'd0);
    rst_n = 1'b0; cpu_req_valid = 1'b0;
    @(negedge clk);
    check("t5_rst_memreq", 32'(mem_req), 32'd0);
    check("t5_rst_ready", 32'(cpu_req_ready), 32'd1);
    rst_n = 1'b1; ack_delay = 0;
    do_req(1'b0, 10'h000, '0);
    check("t5_post_lat", 32'(r_lat), 32'd10);
    check("t5_post_hit", 32'(r_hit), 32'd0);
    check("t5_post_data", r_data, 32'h0000_00FF);

    // Set 1: fill, then alternating hits one response every 2 cycles
    do_req(1'b0, 10'h010, '0);
    check("t6_fill_hit", 32'(r_hit), 32'd0);
    check("t6_fill_data", r_data, 32'h0004_0004);
    prev_cyc = r_cyc;
    mq0 = mreq_cyc;
    for (int k = 0; k < 6; k++) begin
      do_req(t_rw[k], t_addr[k], t_data[k]);
      check("t6_hit", 32'(r_hit), 32'd1);
      check("t6_gap", 32'(r_cyc - prev_cyc), 32'd2);
      if (!t_rw[k]) check("t6_data", r_data, t_data[k]);
      prev_cyc = r_cyc;
    end
    check("t6_memreq", 32'(mreq_cyc - mq0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
